// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes over the image interior. Once the LBP stage
// signals finish, the bins are streamed out in order over valid/ready.
module lbp_histogram #(
    parameter int IMG_W = 128,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             lbp_finish,
    input  logic             hist_clear,
    input  logic             hist_ready,
    output logic             hist_valid,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic [CNT_W-1:0] pix_count,
    output logic             addr_err
);
    localparam int               XW      = $clog2(IMG_W);
    localparam logic [XW-1:0]    EDGE_HI = XW'(IMG_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ACCUM, DUMP, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_bins [256];
    logic             r_finish_q;
    logic             r_hist_valid, r_hist_done, r_addr_err;
    logic [7:0]       r_hist_bin;
    logic [CNT_W-1:0] r_hist_count, r_pix_count;

    logic [XW-1:0]    w_x, w_y;
    logic             w_interior, w_finish_rise, w_count_en, w_xfer, w_last;
    logic [7:0]       w_next_bin;
    logic [CNT_W-1:0] w_bin0_next;

    assign w_x           = lbp_addr[XW-1:0];
    assign w_y           = lbp_addr[2*XW-1:XW];
    assign w_interior    = (w_x != '0) && (w_x != EDGE_HI) && (w_y != '0) && (w_y != EDGE_HI);
    assign w_finish_rise = lbp_finish && !r_finish_q;
    assign w_count_en    = (r_state == ACCUM) && lbp_valid && w_interior && !hist_clear;
    assign w_xfer        = r_hist_valid && hist_ready;
    assign w_last        = (r_hist_bin == 8'hFF);
    assign w_next_bin    = r_hist_bin + 8'd1;

    // The first dump word must already include a pixel arriving with the finish edge.
    assign w_bin0_next = (w_count_en && lbp_data == 8'd0 && r_bins[0] != CNT_MAX)
                       ? r_bins[0] + CNT_W'(1) : r_bins[0];

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) r_state <= ACCUM;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
        w_state_next = r_state;
        if (hist_clear) begin
            w_state_next = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_finish_rise)    w_state_next = DUMP;
                DUMP:    if (w_xfer && w_last) w_state_next = DONE;
                default: ;
            endcase
        end
    end

    // Tracks lbp_finish unconditionally so a level held across a clear cannot re-trigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_finish_q <= 1'b0;
        else       r_finish_q <= lbp_finish;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the bin array is a register file, not RAM, so it can be reset and
        // cleared in one cycle and read-modify-written without a forwarding path.
        if (reset) begin
            for (int i = 0; i < 256; i++) r_bins[i] <= '0;
        end else if (hist_clear) begin
            for (int i = 0; i < 256; i++) r_bins[i] <= '0;
        end else if (w_count_en && r_bins[lbp_data] != CNT_MAX) begin
            r_bins[lbp_data] <= r_bins[lbp_data] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_count <= '0;
            r_addr_err  <= 1'b0;
        end else if (hist_clear) begin
            r_pix_count <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            if (w_count_en && r_pix_count != CNT_MAX) r_pix_count <= r_pix_count + CNT_W'(1);
            if (r_state == ACCUM && lbp_valid && !w_interior) r_addr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_count <= '0;
            r_hist_done  <= 1'b0;
        end else if (hist_clear) begin
            r_hist_valid <= 1'b0;
            r_hist_bin   <= '0;
            r_hist_count <= '0;
            r_hist_done  <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: if (w_finish_rise) begin
                    r_hist_valid <= 1'b1;
                    r_hist_bin   <= '0;
                    r_hist_count <= w_bin0_next;
                end
                DUMP: if (w_xfer) begin
                    if (w_last) begin
                        r_hist_valid <= 1'b0;
                        r_hist_done  <= 1'b1;
                    end else begin
                        r_hist_bin   <= w_next_bin;
                        r_hist_count <= r_bins[w_next_bin];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_hist_bin;
    assign hist_count = r_hist_count;
    assign hist_done  = r_hist_done;
    assign pix_count  = r_pix_count;
    assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_lbp_histogram.sv
// Scoreboard bench for lbp_histogram: an array-based histogram model queues the
// expected dump at each finish rise; a monitor checks every handshake.
module tb_lbp_histogram;
    localparam int CNT_MAX = 16383;

    logic        clk = 1'b0;
    logic        reset, lbp_valid, lbp_finish, hist_clear, hist_ready;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        hist_valid, hist_done, addr_err;
    logic [7:0]  hist_bin;
    logic [13:0] hist_count, pix_count;

    typedef struct {int bin; int count;} exp_t;
    exp_t exp_q[$];

    int model_bins [256];
    int model_pix;
    bit model_err;
    int vectors = 0, miscompares = 0, xfers = 0;
    int stall_left = 0;
    bit stall17_armed = 1'b1;
    bit seen_valid = 1'b0;

    lbp_histogram dut (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .lbp_finish(lbp_finish), .hist_clear(hist_clear),
        .hist_ready(hist_ready), .hist_valid(hist_valid), .hist_bin(hist_bin),
        .hist_count(hist_count), .hist_done(hist_done), .pix_count(pix_count),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 256; b++) model_bins[b] = 0;
        model_pix = 0;
        model_err = 1'b0;
    endtask

    task automatic push_expected();
        xfers = 0;
        for (int b = 0; b < 256; b++) exp_q.push_back('{b, model_bins[b]});
    endtask

    // One pixel result; the model counts it only for interior coordinates.
    task automatic send(input int x, input int y, input int d, input bit fin);
        lbp_valid = 1'b1;
        lbp_addr  = 14'(y * 128 + x);
        lbp_data  = 8'(d);
        if (x >= 1 && x <= 126 && y >= 1 && y <= 126) begin
            if (model_bins[d] < CNT_MAX) model_bins[d]++;
            if (model_pix < CNT_MAX) model_pix++;
        end else begin
            model_err = 1'b1;
        end
        if (fin) begin
            lbp_finish = 1'b1;
            push_expected();
        end
        tick();
    endtask

    task automatic idle();
        lbp_valid = 1'b0;
        tick();
    endtask

    task automatic start_dump();
        lbp_valid  = 1'b0;
        lbp_finish = 1'b1;
        push_expected();
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!hist_done && n < 4000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, hist_done, 1);
        check({tag, "_xfers"}, xfers, 256);
        check({tag, "_leftover"}, exp_q.size(), 0);
        check({tag, "_valid_low"}, hist_valid, 0);
        check({tag, "_pix"}, pix_count, model_pix);
        check({tag, "_err"}, addr_err, model_err);
    endtask

    task automatic do_clear();
        hist_clear = 1'b1;
        model_clear();
        tick();
        hist_clear = 1'b0;
        check("clr_pix", pix_count, 0);
        check("clr_err", addr_err, 0);
        check("clr_done", hist_done, 0);
        check("clr_valid", hist_valid, 0);
    endtask

    // Downstream ready: random, with one 5-cycle stall the first time bin 17 appears.
    initial begin
        hist_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                hist_ready = 1'b0;
                stall_left--;
            end else if (stall17_armed && hist_valid && hist_bin == 8'd17) begin
                stall17_armed = 1'b0;
                hist_ready    = 1'b0;
                stall_left    = 4;
            end else begin
                hist_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: stability while stalled, then order and value on each handshake.
    initial begin
        bit   prev_stall = 1'b0;
        int   prev_bin = 0, prev_count = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else if (hist_valid) begin
                seen_valid = 1'b1;
                if (prev_stall) begin
                    check("stall_bin", hist_bin, prev_bin);
                    check("stall_count", hist_count, prev_count);
                end
                if (hist_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", hist_bin, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("dump_bin", hist_bin, e.bin);
                        check($sformatf("dump_count_bin%0d", e.bin), hist_count, e.count);
                    end
                    xfers++;
                end
                prev_stall = !hist_ready;
                prev_bin   = hist_bin;
                prev_count = hist_count;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
        lbp_finish = 1'b0; hist_clear = 1'b0;
        model_clear();
        #1;
        check("rst_valid", hist_valid, 0);
        check("rst_bin", hist_bin, 0);
        check("rst_count", hist_count, 0);
        check("rst_done", hist_done, 0);
        check("rst_pix", pix_count, 0);
        check("rst_err", addr_err, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Uniform image: every interior pixel carries code 0xAA.
        for (int y = 1; y <= 126; y++)
            for (int x = 1; x <= 126; x++) send(x, y, 8'hAA, 1'b0);
        idle();
        check("uni_pix_pre", pix_count, 15876);
        start_dump();
        wait_done("uni");

        // Border rejection.
        lbp_finish = 1'b0;
        tick();
        do_clear();
        send(0, 0, 5, 1'b0);   idle();
        send(127, 0, 5, 1'b0); idle();
        send(0, 127, 5, 1'b0); idle();
        send(1, 1, 5, 1'b0);   idle();
        check("bdr_pix", pix_count, 1);
        check("bdr_err", addr_err, 1);
        start_dump();
        wait_done("bdr");

        // Back-to-back same bin, last pixel coincident with the finish rise.
        lbp_finish = 1'b0;
        tick();
        do_clear();
        send(2, 1, 8'hFF, 1'b0);
        send(3, 1, 8'hFF, 1'b0);
        send(4, 1, 8'hFF, 1'b1);
        idle();
        wait_done("b2b");

        // Random image, including occasional border addresses and gaps.
        lbp_finish = 1'b0;
        tick();
        do_clear();
        for (int i = 0; i < 600; i++) begin
            send($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 255), 1'b0);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        start_dump();
        wait_done("rnd");

        // Clear in DONE with finish held high; a coincident pixel is dropped.
        hist_clear = 1'b1;
        lbp_valid  = 1'b1;
        lbp_addr   = 14'(5 * 128 + 5);
        lbp_data   = 8'd9;
        model_clear();
        tick();
        hist_clear = 1'b0;
        lbp_valid  = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("clr_hi_no_dump", seen_valid, 0);
        check("clr_hi_done", hist_done, 0);
        check("clr_hi_pix", pix_count, 0);
        lbp_finish = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            send($urandom_range(1, 126), $urandom_range(1, 126), 3, 1'b0);
            idle();
        end
        start_dump();
        wait_done("rerun");
        check("rerun_pix10", pix_count, 10);

        // Reset in the middle of a dump.
        lbp_finish = 1'b0;
        tick();
        do_clear();
        for (int i = 0; i < 50; i++)
            send($urandom_range(1, 126), $urandom_range(1, 126), $urandom_range(0, 255), 1'b0);
        idle();
        start_dump();
        n = 0;
        while (!(hist_valid && hist_bin == 8'd100) && n < 2000) begin
            tick();
            n++;
        end
        check("mid_reach_bin100", hist_bin, 100);
        reset      = 1'b1;
        lbp_finish = 1'b0;
        #1;
        check("mid_rst_valid", hist_valid, 0);
        check("mid_rst_bin", hist_bin, 0);
        check("mid_rst_count", hist_count, 0);
        exp_q.delete();
        model_clear();
        tick();
        reset = 1'b0;
        tick(); tick();
        start_dump();
        wait_done("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lbp_histogram.md
Name: lbp_histogram

Overview:
- Downstream consumer of the LBP stage's write port (lbp_valid/lbp_addr/lbp_data/finish).
- Accumulates a 256-bin histogram of LBP codes over the 128x128 image. Only interior pixels (x,y in 1..126) are counted.
- After the LBP stage signals finish, the block streams all 256 bin counts out over a valid/ready interface.
- Holds the histogram until cleared, then is ready for the next image.

Parameters:
- IMG_W, 128, image width in pixels; a power of two, so x = addr[6:0] and y = addr[13:7].
- CNT_W, 14, width of each bin counter and of the pixel counter; 126*126 = 15876 fits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- lbp_valid  input  1  one-cycle pulse per LBP result from the LBP stage.
- lbp_addr  input  14  pixel address {y[6:0], x[6:0]}.
- lbp_data  input  8  LBP code; selects the bin.
- lbp_finish  input  1  LBP stage done; a level that may stay high indefinitely.
- hist_clear  input  1  pulse: zero all bins and re-arm.
- hist_ready  input  1  downstream accepts the current bin.
- hist_valid  output  1  hist_bin/hist_count are valid.
- hist_bin  output  8  bin index being output.
- hist_count  output  14  count for hist_bin.
- hist_done  output  1  level, high once all 256 bins have been transferred.
- pix_count  output  14  number of interior pixels counted.
- addr_err  output  1  sticky flag: a border or out-of-range address was received.

Behaviour:
- Reset (asynchronous):
  - all 256 bins = 0, pix_count = 0, addr_err = 0.
  - hist_valid = 0, hist_bin = 0, hist_count = 0, hist_done = 0.
  - finish_q = 0 (registered copy of lbp_finish); state = ACCUM.
- States: ACCUM, DUMP, DONE. All outputs are registered.
- ACCUM:
  - On lbp_valid with an interior address: bin[lbp_data] += 1 and pix_count += 1, in the same cycle (single-cycle read-modify-write).
  - Back-to-back pulses to the same bin on consecutive cycles must both count; no lost updates.
  - Interior address: x in 1..126 and y in 1..126.
  - Border address (x or y in {0,127}) with lbp_valid: no count change; addr_err <= 1.
  - Bin counters and pix_count saturate at 2^CNT_W-1; they never wrap.
- ACCUM -> DUMP:
  - Triggered by the rising edge of lbp_finish (lbp_finish=1 and finish_q=0).
  - An lbp_valid in that same cycle is still counted.
  - The first dump output is registered next cycle: hist_valid=1, hist_bin=0, hist_count = the bin 0 value including that final pixel.
- DUMP:
  - A transfer occurs when hist_valid and hist_ready are both 1.
  - On a transfer, hist_bin increments and hist_count loads the next bin on the following cycle.
  - While hist_valid=1 and hist_ready=0, hist_bin and hist_count hold stable.
  - hist_valid stays high between transfers; there are no bubbles.
  - lbp_valid is ignored.
  - On the transfer of bin 255: next cycle hist_valid=0, hist_done=1, state -> DONE.
- DONE:
  - hist_done stays high; the bins are retained; lbp_valid is ignored.
  - A still-high lbp_finish does not re-trigger a dump.
- hist_clear, in any state:
  - Next cycle: bins and pix_count = 0, addr_err = 0, hist_valid = 0, hist_done = 0, hist_bin = 0, state = ACCUM.
  - A coincident lbp_valid is dropped (clear wins).
  - finish_q keeps tracking lbp_finish, so a finish that stays high across the clear does not start a dump. A new low-to-high transition is required.
- Reset mid-DUMP aborts the dump immediately (asynchronous). The bins are lost.
- Width rule: hist_count is CNT_W bits, zero-extended; no truncation is possible for legal streams.

Test Plan:
- Uniform stream:
  - Stimulus: 15876 interior pixels, each with lbp_data = 8'hAA, then raise lbp_finish.
  - Required: bin 0xAA = 15876, all other bins 0, pix_count = 15876, addr_err = 0, exactly 256 transfers, hist_done = 1.
- Border rejection:
  - Stimulus: valids at addr 0, 127, 16256, and 129 (x=1,y=1), all with data 5.
  - Required: bin 5 = 1, pix_count = 1, addr_err = 1.
- Back-to-back same bin:
  - Stimulus: 3 consecutive-cycle valids with data 0xFF at interior addresses, the last one coincident with the lbp_finish rise.
  - Required: dumped bin 255 = 3.
- Backpressure:
  - Stimulus: during DUMP, hold hist_ready low for 5 cycles at bin 17, and toggle ready randomly elsewhere.
  - Required: hist_bin/hist_count stable while stalled; bins arrive in order 0..255 exactly once each.
- Clear and re-run:
  - Stimulus: in DONE with lbp_finish still high, pulse hist_clear.
  - Required: no new dump while lbp_finish stays high. After lbp_finish goes low, a second image of 10 pixels of code 3, and a new finish rise, the dump shows bin 3 = 10 and pix_count = 10.
- Reset mid-dump:
  - Stimulus: assert reset at bin 100.
  - Required: hist_valid = 0, hist_bin = 0, hist_count = 0, and all bins read back 0 after the next dump.
